axi_sram_slave: RTL and testbench

- AXI3-style responder holding a word-addressed SRAM array; the target end of the CPU's SRAM/cache-to-AXI bridge.
- Used as the memory model and SoC slave for bridge bring-up and for the cache refill and writeback paths.
- Read and write channels are independent: one read burst and one write burst may be in flight at the same time.
- Burst length: 1 to 256 beats.

---
 rtl/axi_sram_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3-style word-addressed SRAM responder with independent read and write burst engines.
// Reads insert RD_LATENCY idle cycles before the first beat; writes honour byte strobes.
module axi_sram_slave #(
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT   = 4'(RD_LATENCY);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [31:0] r_mem [DEPTH];

  logic [1:0]            r_rState;
  logic [1:0]            w_rNext;
  logic                  r_arready;
  logic [3:0]            r_rId;
  logic [DEPTH_LOG2-1:0] r_rAddr;
  logic [DEPTH_LOG2-1:0] w_rAddrNext;
  logic [DEPTH_LOG2-1:0] w_arIdx;
  logic [7:0]            r_rLen;
  logic [7:0]            r_rBeat;
  logic [3:0]            r_rCnt;
  logic                  r_rIncr;
  logic [31:0]           r_rdata;
  logic                  w_arHs;
  logic                  w_rHs;

  logic [1:0]            r_wState;
  logic [1:0]            w_wNext;
  logic                  r_awready;
  logic [3:0]            r_wId;
  logic [DEPTH_LOG2-1:0] r_wAddr;
  logic [DEPTH_LOG2-1:0] w_wAddrNext;
  logic [7:0]            r_wLen;
  logic [7:0]            r_wBeat;
  logic                  r_wIncr;
  logic                  r_wErr;
  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_wFinal;

  logic                  w_unused;

  // Sideband fields and the dropped address bits are intentionally ignored.
  assign w_unused = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid,
                      araddr[31:DEPTH_LOG2+2], araddr[1:0], awaddr[31:DEPTH_LOG2+2], awaddr[1:0]};

  assign w_arIdx     = araddr[DEPTH_LOG2+1:2];
  assign w_arHs      = arvalid && r_arready;
  assign w_rHs       = (r_rState == R_DATA) && rready;
  assign w_rAddrNext = r_rIncr ? r_rAddr + 1'b1 : r_rAddr;

  always_comb begin
    w_rNext = r_rState;
    case (r_rState)
      R_IDLE:  if (w_arHs) w_rNext = (LAT == 4'd0) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_rCnt == 4'd1) w_rNext = R_DATA;
      R_DATA:  if (w_rHs && (r_rBeat == r_rLen)) w_rNext = R_IDLE;
      default: w_rNext = R_IDLE;
    endcase
  end

  // arready is registered so it stays low through reset and rises one cycle after a burst ends.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rState  <= R_IDLE;
      r_arready <= 1'b0;
      r_rId     <= '0;
      r_rAddr   <= '0;
      r_rLen    <= '0;
      r_rBeat   <= '0;
      r_rCnt    <= '0;
      r_rIncr   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rState  <= w_rNext;
      r_arready <= (w_rNext == R_IDLE);
      case (r_rState)
        R_IDLE: begin
          if (w_arHs) begin
            r_rId   <= arid;
            r_rAddr <= w_arIdx;
            r_rLen  <= arlen;
            r_rBeat <= '0;
            r_rCnt  <= LAT;
            r_rIncr <= (arburst != 2'b00);
            if (LAT == 4'd0) r_rdata <= r_mem[w_arIdx];
          end
        end
        R_WAIT: begin
          r_rCnt <= r_rCnt - 4'd1;
          if (r_rCnt == 4'd1) r_rdata <= r_mem[r_rAddr];
        end
        R_DATA: begin
          if (w_rHs) begin
            r_rBeat <= r_rBeat + 8'd1;
            r_rAddr <= w_rAddrNext;
            r_rdata <= r_mem[w_rAddrNext];
          end
        end
        default: ;
      endcase
    end
  end

  assign w_awHs      = awvalid && r_awready;
  assign w_wHs       = (r_wState == W_DATA) && wvalid;
  assign w_wFinal    = (r_wBeat == r_wLen);
  assign w_wAddrNext = r_wIncr ? r_wAddr + 1'b1 : r_wAddr;

  always_comb begin
    w_wNext = r_wState;
    case (r_wState)
      W_IDLE:  if (w_awHs) w_wNext = W_DATA;
      W_DATA:  if (w_wHs && w_wFinal) w_wNext = W_RESP;
      W_RESP:  if (bready) w_wNext = W_IDLE;
      default: w_wNext = W_IDLE;
    endcase
  end

  // The beat counter alone ends a burst; a misplaced wlast only poisons the response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wState  <= W_IDLE;
      r_awready <= 1'b0;
      r_wId     <= '0;
      r_wAddr   <= '0;
      r_wLen    <= '0;
      r_wBeat   <= '0;
      r_wIncr   <= 1'b0;
      r_wErr    <= 1'b0;
    end else begin
      r_wState  <= w_wNext;
      r_awready <= (w_wNext == W_IDLE);
      case (r_wState)
        W_IDLE: begin
          if (w_awHs) begin
            r_wId   <= awid;
            r_wAddr <= awaddr[DEPTH_LOG2+1:2];
            r_wLen  <= awlen;
            r_wBeat <= '0;
            r_wIncr <= (awburst != 2'b00);
            r_wErr  <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_wHs) begin
            r_wAddr <= w_wAddrNext;
            r_wBeat <= r_wBeat + 8'd1;
            if (wlast != w_wFinal) r_wErr <= 1'b1;
          end
        end
        W_RESP: begin
          if (bready) r_wErr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The array has no reset so its contents survive areset.
  always_ff @(posedge aclk) begin
    if (!areset && w_wHs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[r_wAddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign arready = r_arready;
  assign rvalid  = (r_rState == R_DATA);
  assign rlast   = (r_rState == R_DATA) && (r_rBeat == r_rLen);
  assign rid     = r_rId;
  assign rdata   = r_rdata;
  assign rresp   = 2'b00;

  assign awready = r_awready;
  assign wready  = (r_wState == W_DATA);
  assign bvalid  = (r_wState == W_RESP);
  assign bid     = r_wId;
  assign bresp   = r_wErr ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus tasks push expected R/B responses,
// a monitor pops and compares them whenever the DUT completes a handshake.
module tb_axi_sram_slave;

  localparam int RD_LAT = 2;

  logic        aclk;
  logic        areset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } rBeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bResp_t;

  rBeat_t      rExp[$];
  bResp_t      bExp[$];
  logic [31:0] wBuf [16];
  logic [31:0] rBuf [16];
  bit          rreadyToggle;
  int          checks;
  int          errors;

  axi_sram_slave #(.DEPTH_LOG2(12), .RD_LATENCY(RD_LAT)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // rready is either held high or toggled every cycle to exercise stalls.
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (rreadyToggle) rready = ~rready;
      else rready = 1'b1;
    end
  end

  // Monitor: compares every completed R and B handshake against the scoreboard.
  initial begin : monitor
    logic        prevStall;
    logic [31:0] prevData;
    rBeat_t      e;
    bResp_t      b;
    prevStall = 1'b0;
    prevData  = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall && rvalid) checkOutput("rdata_stable", 64'(rdata), 64'(prevData));
        if (rvalid && rready) begin
          if (rExp.size() == 0) begin
            checkOutput("r_unexpected", 64'(rvalid), 64'd0);
          end else begin
            e = rExp.pop_front();
            checkOutput("r_beat", 64'({rid, rdata, rlast, rresp}), 64'({e.id, e.data, e.last, 2'b00}));
          end
        end
        prevStall = rvalid && !rready;
        prevData  = rdata;
        if (bvalid && bready) begin
          if (bExp.size() == 0) begin
            checkOutput("b_unexpected", 64'(bvalid), 64'd0);
          end else begin
            b = bExp.pop_front();
            checkOutput("b_resp", 64'({bid, bresp}), 64'({b.id, b.resp}));
          end
        end
      end
    end
  end

  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] strb, input int errBeat, input logic [1:0] expResp);
    bit ok;
    bExp.push_back('{id, expResp});
    awid = id; awaddr = addr; awlen = len; awburst = 2'b01; awvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge aclk);
      ok = awready;
    end
    if (!ok) checkOutput("aw_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = wBuf[i];
      wstrb  = strb;
      wlast  = (i == int'(len)) != (i == errBeat);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge aclk);
        ok = wready;
      end
      if (!ok) checkOutput("w_timeout", 64'd0, 64'd1);
      @(posedge aclk);
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input bit checkLat);
    bit ok;
    int n;
    for (int i = 0; i <= int'(len); i++) rExp.push_back('{id, rBuf[i], (i == int'(len))});
    arid = id; araddr = addr; arlen = len; arburst = 2'b01; arvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge aclk);
      ok = arready;
    end
    if (!ok) checkOutput("ar_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1 arvalid = 1'b0;
    if (checkLat) begin
      n  = 0;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge aclk);
        n++;
        ok = rvalid;
      end
      checkOutput("rd_latency", 64'(n), 64'(RD_LAT + 1));
    end
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 2000; c++) begin
      if (rExp.size() == 0 && bExp.size() == 0) break;
      @(posedge aclk);
    end
    checkOutput("drain", 64'(rExp.size() + bExp.size()), 64'd0);
    rExp.delete();
    bExp.delete();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus();
    bit ok;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("reset_outputs", 64'({arready, awready, rvalid, wready, bvalid, rlast}), 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    checkOutput("ready_after_reset", 64'({arready, awready}), 64'd3);
    @(posedge aclk);
    #1;

    // Single write then read with latency measurement.
    wBuf[0] = 32'hDEADBEEF;
    writeBurst(4'd3, 32'h100, 8'd0, 4'hF, -1, 2'b00);
    waitDrain();
    rBuf[0] = 32'hDEADBEEF;
    readBurst(4'd2, 32'h100, 8'd0, 1'b1);
    waitDrain();

    // Cache-line refill with rready stalls.
    for (int i = 0; i < 4; i++) wBuf[i] = 32'(i);
    writeBurst(4'd4, 32'h1C00, 8'd3, 4'hF, -1, 2'b00);
    waitDrain();
    for (int i = 0; i < 4; i++) rBuf[i] = 32'(i);
    rreadyToggle = 1'b1;
    readBurst(4'd1, 32'h1C00, 8'd3, 1'b0);
    waitDrain();
    rreadyToggle = 1'b0;

    // Partial strobe merge.
    wBuf[0] = 32'h11223344;
    writeBurst(4'd12, 32'h200, 8'd0, 4'hF, -1, 2'b00);
    wBuf[0] = 32'hAABBCCDD;
    writeBurst(4'd13, 32'h200, 8'd0, 4'b0101, -1, 2'b00);
    waitDrain();
    rBuf[0] = 32'h11BB33DD;
    readBurst(4'd14, 32'h200, 8'd0, 1'b0);
    waitDrain();

    // Address aliasing: bit 14 is above the array index.
    rBuf[0] = 32'hDEADBEEF;
    readBurst(4'd15, 32'h4100, 8'd0, 1'b0);
    waitDrain();

    // Overlapped AR and AW in the same cycle.
    rBuf[0] = 32'd1; rBuf[1] = 32'd2;
    wBuf[0] = 32'h55; wBuf[1] = 32'h66;
    fork
      readBurst(4'd5, 32'h1C04, 8'd1, 1'b0);
      writeBurst(4'd6, 32'h300, 8'd1, 4'hF, -1, 2'b00);
      begin
        @(negedge aclk);
        checkOutput("both_ready", 64'({arready, awready}), 64'd3);
      end
    join
    waitDrain();
    rBuf[0] = 32'h55; rBuf[1] = 32'h66;
    readBurst(4'd6, 32'h300, 8'd1, 1'b0);
    waitDrain();

    // Early wlast still writes all beats but reports SLVERR; the next burst is clean.
    for (int i = 0; i < 4; i++) wBuf[i] = 32'hA0A0A0A0 + 32'(i);
    writeBurst(4'd7, 32'h400, 8'd3, 4'hF, 1, 2'b10);
    waitDrain();
    for (int i = 0; i < 4; i++) rBuf[i] = 32'hA0A0A0A0 + 32'(i);
    readBurst(4'd9, 32'h400, 8'd3, 1'b0);
    wBuf[0] = 32'h500;
    writeBurst(4'd10, 32'h500, 8'd0, 4'hF, -1, 2'b00);
    waitDrain();

    // Reset during beat 2 of an 8-beat read.
    for (int i = 0; i < 8; i++) wBuf[i] = 32'h600 + 32'(i);
    writeBurst(4'd11, 32'h600, 8'd7, 4'hF, -1, 2'b00);
    waitDrain();
    for (int i = 0; i < 8; i++) rBuf[i] = 32'h600 + 32'(i);
    readBurst(4'd8, 32'h600, 8'd7, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge aclk);
      ok = (rExp.size() <= 6);
    end
    if (!ok) checkOutput("beat2_timeout", 64'd0, 64'd1);
    #1 areset = 1'b1;
    @(posedge aclk);
    #1 rExp.delete();
    @(negedge aclk);
    checkOutput("mid_reset_outputs", 64'({rvalid, arready, rlast}), 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    checkOutput("arready_after_release", 64'(arready), 64'd1);
    @(posedge aclk);
    #1;
    rBuf[0] = 32'hDEADBEEF;
    readBurst(4'd2, 32'h100, 8'd0, 1'b0);
    waitDrain();
    rBuf[0] = 32'h606; rBuf[1] = 32'h607;
    readBurst(4'd3, 32'h618, 8'd1, 1'b0);
    waitDrain();
  endtask

  initial begin
    checks = 0; errors = 0; rreadyToggle = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
